serial_sub_n: RTL and testbench
===============================

Name: serial_sub_n

Overview:
- Parametrised, bit-serial successor to the single-bit half subtractor.
- Computes an N-bit unsigned difference LSB-first, one bit per clock, using the half-subtractor difference/borrow equations extended with a registered borrow.
- Start/busy/done handshake, borrow-in for chaining, and a swap mode (b − a).
- Used where area matters more than latency: arithmetic datapaths, counters, comparison units.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- swap  input  1  0: compute a − b; 1: compute b − a. Sampled with start.
- a  input  WIDTH  minuend operand (subtrahend when swap=1). Sampled with start.
- b  input  WIDTH  subtrahend operand (minuend when swap=1). Sampled with start.
- borrow_in  input  1  initial borrow into bit 0. Sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when result is valid.
- diff  output  WIDTH  result, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when minuend < subtrahend + borrow_in.
- zero  output  1  1 when diff == 0; valid with done.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0, zero=0.
  - Operand shift registers and counter cleared.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k loads operands: x=swap?b:a, y=swap?a:b; br=borrow_in; cnt=0; goto RUN.
  - diff, borrow_out and zero keep their previous values until the next load.
- RUN, one bit per edge on x[0], y[0], br:
  - d = x^y^br
  - br' = (~x&y) | (~(x^y)&br)
  - d shifts into the result register MSB; x and y shift right; cnt++.
  - After the WIDTH-th RUN edge (edge k+WIDTH), goto DONE.
  - At that edge: diff = full shifted result, borrow_out = br', zero = (diff==0).
- DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH); goto IDLE unconditionally.
- busy=1 exactly in cycles where state=RUN: WIDTH cycles, from after edge k until edge k+WIDTH.
- Latency: start sampled at edge k, done high during cycle following edge k+WIDTH, giving WIDTH+1 edges start-to-done.
- start while in RUN or DONE is ignored: no queueing, operands not resampled. Earliest accepted restart is the first IDLE cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
- Operand changes on a, b, swap or borrow_in after the load edge have no effect on the result in flight.
- Reset mid-RUN or in DONE aborts the operation: no done pulse; outputs return to reset values.
- WIDTH=1: RUN lasts one cycle; diff = a^b^borrow_in.
  - With borrow_in=0, result equals the half subtractor: diff=a^b, borrow_out=~a&b.
- Arithmetic: diff = (minuend − subtrahend − borrow_in) mod 2^WIDTH. borrow_out is the unsigned underflow flag.

Test Plan:
- Basic, WIDTH=8: a=0x5A, b=0x3C, swap=0, bin=0 → busy 8 cycles, done pulse at edge+9, diff=0x1E, borrow_out=0, zero=0.
- Underflow: a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Then a=0x10, b=0x10, bin=1 → diff=0xFF, borrow_out=1. Then bin=0 → diff=0x00, zero=1.
- Swap: a=0x05, b=0x09, swap=1 → diff=0x04, borrow_out=0. Same operands with swap=0 → diff=0xFC, borrow_out=1.
- Ignored start: pulse start with a=0x01, b=0x01 during busy of an a=0x80, b=0x01 operation → single done, diff=0x7F. Next start accepted only in the cycle after done.
- Reset mid-op: assert rst at the 4th RUN cycle → busy=0, diff=0 next cycle, no done pulse. A fresh start afterwards completes normally.
- WIDTH=1 build: all four (a,b) combinations with bin=0 → (0,0)→0/0, (0,1)→1/1, (1,0)→1/0, (1,1)→0/0 (diff/borrow_out). done at edge+2.

Source files
------------

// File: rtl/serial_sub_n_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues start with operands; the slave side returns busy/done and the result.
interface serial_sub_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             swap;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, swap, a, b, borrow_in,
    input  busy, done, diff, borrow_out, zero
  );

  modport slave (
    input  start, swap, a, b, borrow_in,
    output busy, done, diff, borrow_out, zero
  );
endinterface

// File: rtl/serial_sub_n.sv
// Bit-serial N-bit subtractor: one half-subtractor step per clock, LSB first,
// with a registered borrow, start/busy/done handshake and optional operand swap.
module serial_sub_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_n_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] x_load;
  logic [WIDTH-1:0] y_load;
  logic             bit_d;
  logic             br_next;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Swap is resolved at load time so the serial datapath only ever sees minuend/subtrahend.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_operand_sel
      assign x_load[gi] = bus.swap ? bus.b[gi] : bus.a[gi];
      assign y_load[gi] = bus.swap ? bus.a[gi] : bus.b[gi];
    end
  endgenerate

  assign bit_d    = x_reg[0] ^ y_reg[0] ^ br_reg;
  assign br_next  = (~x_reg[0] & y_reg[0]) | (~(x_reg[0] ^ y_reg[0]) & br_reg);
  // New bit enters at the MSB; after WIDTH steps the LSB-first bits are in order.
  assign res_cat  = {bit_d, res_reg};
  assign res_next = res_cat[WIDTH:1];
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      res_reg        <= '0;
      br_reg         <= 1'b0;
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      zero_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            x_reg     <= x_load;
            y_reg     <= y_load;
            br_reg    <= bus.borrow_in;
            res_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          x_reg   <= x_reg >> 1;
          y_reg   <= y_reg >> 1;
          br_reg  <= br_next;
          res_reg <= res_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_bit) begin
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            diff_reg       <= res_next;
            borrow_out_reg <= br_next;
            zero_reg       <= (res_next == '0);
            state_reg      <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_out_reg;
  assign bus.zero       = zero_reg;

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed bench for serial_sub_n: an 8-bit and a 1-bit instance share clock and reset;
// expected results are queued at issue and compared when done pulses.
module tb_serial_sub_n;

  logic clk;
  logic rst;

  serial_sub_n_if #(.WIDTH(8)) if8 ();
  serial_sub_n_if #(.WIDTH(1)) if1 ();

  serial_sub_n #(.WIDTH(8), .CNT_W(6)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_sub_n #(.WIDTH(1), .CNT_W(6)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sw,
                       input logic [7:0] av, input logic [7:0] bv, input logic bin);
    if (w == 8) begin
      if8.start = st; if8.swap = sw; if8.a = av; if8.b = bv; if8.borrow_in = bin;
    end else begin
      if1.start = st; if1.swap = sw; if1.a = av[0]; if1.b = bv[0]; if1.borrow_in = bin;
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done,
                        output logic [7:0] d, output logic bo, output logic z);
    if (w == 8) begin
      busy = if8.busy; done = if8.done; d = if8.diff; bo = if8.borrow_out; z = if8.zero;
    end else begin
      busy = if1.busy; done = if1.done; d = {7'b0, if1.diff}; bo = if1.borrow_out; z = if1.zero;
    end
  endtask

  // Issue one operation from a negedge; optionally pulse a competing start at cycle inj_cyc.
  task automatic run_op(input string name, input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic sw, input logic bin, input int inj_cyc,
                        input logic [7:0] ia, input logic [7:0] ib);
    int         m, s, t, mask;
    exp_t       e;
    int         busy_n, done_n, done_at;
    logic       busy, done, bo, z;
    logic [7:0] d;
    mask = (1 << w) - 1;
    m    = sw ? (int'(bv) & mask) : (int'(av) & mask);
    s    = sw ? (int'(av) & mask) : (int'(bv) & mask);
    t    = m - s - int'(bin);
    e.bo = (t < 0);
    e.d  = 8'(t & mask);
    e.z  = ((t & mask) == 0);
    sb.push_back(e);
    drive(w, 1'b1, sw, av, bv, bin);
    @(posedge clk);
    busy_n = 0; done_n = 0; done_at = 0;
    for (int j = 1; j <= w + 6; j++) begin
      @(negedge clk);
      sample(w, busy, done, d, bo, z);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = j;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({name, ".diff"}, 64'(d), 64'(e.d));
          check({name, ".borrow_out"}, 64'(bo), 64'(e.bo));
          check({name, ".zero"}, 64'(z), 64'(e.z));
        end else begin
          check({name, ".unexpected_done"}, 64'(1), 64'(0));
        end
      end
      if (j == inj_cyc) drive(w, 1'b1, 1'b0, ia, ib, 1'b0);
      else              drive(w, 1'b0, ~sw, ~av, ~bv, ~bin);
    end
    drive(w, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check({name, ".busy_cycles"}, 64'(busy_n), 64'(w));
    check({name, ".done_cycle"}, 64'(done_at), 64'(w + 1));
    check({name, ".done_count"}, 64'(done_n), 64'(1));
    $display("op %s w=%0d a=%0h b=%0h swap=%0d bin=%0d -> diff=%0h bo=%0d zero=%0d",
             name, w, av, bv, sw, bin, d, bo, z);
  endtask

  initial begin
    logic       busy, done, bo, z;
    logic [7:0] d;
    int         done_n;

    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(8, busy, done, d, bo, z);
    check("rst8.busy", 64'(busy), 64'(0));
    check("rst8.done", 64'(done), 64'(0));
    check("rst8.diff", 64'(d), 64'(0));
    check("rst8.borrow_out", 64'(bo), 64'(0));
    check("rst8.zero", 64'(z), 64'(0));
    sample(1, busy, done, d, bo, z);
    check("rst1.busy", 64'(busy), 64'(0));
    check("rst1.diff", 64'(d), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("basic",   8, 8'h5A, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("under1",  8, 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("under2",  8, 8'h10, 8'h10, 1'b0, 1'b1, 0, 8'h00, 8'h00);
    run_op("zero",    8, 8'h10, 8'h10, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("swap1",   8, 8'h05, 8'h09, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    run_op("swap0",   8, 8'h05, 8'h09, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("ign_run", 8, 8'h80, 8'h01, 1'b0, 1'b0, 3, 8'h01, 8'h01);
    run_op("ign_done",8, 8'h22, 8'h02, 1'b0, 1'b0, 9, 8'h01, 8'h01);

    // Abort in the 4th RUN cycle; diff currently holds 0x20 so a cleared result is visible.
    drive(8, 1'b1, 1'b0, 8'h33, 8'h11, 1'b0);
    @(posedge clk);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sample(8, busy, done, d, bo, z);
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.diff", 64'(d), 64'(0));
    check("abort.borrow_out", 64'(bo), 64'(0));
    done_n = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      sample(8, busy, done, d, bo, z);
      if (done || busy) done_n++;
    end
    check("abort.no_activity", 64'(done_n), 64'(0));
    $display("op abort w=8 a=33 b=11 -> reset in RUN, diff=%0h", d);

    run_op("fresh",   8, 8'hC8, 8'h64, 1'b0, 1'b1, 0, 8'h00, 8'h00);
    run_op("w1_00",   1, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("w1_01",   1, 8'h00, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("w1_10",   1, 8'h01, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("w1_11",   1, 8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_op("w1_11b",  1, 8'h01, 8'h01, 1'b0, 1'b1, 0, 8'h00, 8'h00);
    run_op("w1_swap", 1, 8'h01, 8'h00, 1'b1, 1'b0, 0, 8'h00, 8'h00);

    check("sb.empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
